// File: rtl/sprite_draw_ctrl.sv
// sprite_draw_ctrl
//   Per-frame sequencer for the monochrome sprite path. Once per frame tick it
//   erases the sprite at its old position, moves it one pixel diagonally with
//   edge bounce, then redraws it from the 1-bit sprite ROM. After reset a
//   single draw pass runs (no erase).
//
// Ports
//   clock     in   system clock
//   reset     in   synchronous, active-high reset
//   enable    in   animation enable; gates frame ticks only
//   rom_q     in   sprite ROM data, valid one cycle after rom_addr
//   rom_addr  out  sprite ROM address (cy*SPRITE_W + cx)
//   x, y      out  plot coordinates
//   colour    out  plot colour
//   plot      out  write strobe to the VGA adapter
//   busy      out  high while erasing, moving or drawing
//
// state | meaning
// ------+-----------------------------------------------------------
// WAIT  | idle, waiting for a frame tick (or a pending tick)
// ERASE | raster over the sprite at the old position in BG_COLOUR
// MOVE  | one cycle: step position, bounce at screen edges
// DRAW  | raster over the sprite at the new position from the ROM
module sprite_draw_ctrl #(
   parameter int          SPRITE_W     = 16,
   parameter int          SPRITE_H     = 16,
   parameter int          ADDR_W       = 8,
   parameter int          SCREEN_W     = 160,
   parameter int          SCREEN_H     = 120,
   parameter int          FRAME_CYCLES = 833334,
   parameter logic [2:0]  FG_COLOUR    = 3'b111,
   parameter logic [2:0]  BG_COLOUR    = 3'b000
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              enable,
   input  logic              rom_q,
   output logic [ADDR_W-1:0] rom_addr,
   output logic [7:0]        x,
   output logic [6:0]        y,
   output logic [2:0]        colour,
   output logic              plot,
   output logic              busy
);

   localparam int XMAX = SCREEN_W - SPRITE_W;
   localparam int YMAX = SCREEN_H - SPRITE_H;
   localparam int CX_W = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
   localparam int CY_W = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;
   localparam int FC_W = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;

   typedef enum logic [1:0] {
      S_WAIT  = 2'd0,
      S_ERASE = 2'd1,
      S_MOVE  = 2'd2,
      S_DRAW  = 2'd3
   } state_t;

   state_t          state, state_d;
   logic [CX_W-1:0] cx;
   logic [CY_W-1:0] cy;
   logic [7:0]      pos_x;
   logic [6:0]      pos_y;
   logic            dir_x, dir_y;
   logic [FC_W-1:0] frame_cnt;
   logic            pending;
   logic            draw_q;
   logic            tick, issue, last_step, go;

   assign tick      = (frame_cnt == FC_W'(FRAME_CYCLES - 1));
   assign issue     = (state == S_ERASE) || (state == S_DRAW);
   assign last_step = (cx == CX_W'(SPRITE_W - 1)) && (cy == CY_W'(SPRITE_H - 1));
   assign go        = (tick && enable) || pending;
   assign rom_addr  = ADDR_W'(cy) * ADDR_W'(SPRITE_W) + ADDR_W'(cx);

   always_ff @(posedge clock) begin
      if (reset) state <= S_DRAW;
      else       state <= state_d;
   end

   always_comb begin
      state_d = state;
      busy    = 1'b1;
      case (state)
         S_WAIT: begin
            busy = 1'b0;
            if (go) state_d = S_ERASE;
         end
         S_ERASE: if (last_step) state_d = S_MOVE;
         S_MOVE:  state_d = S_DRAW;
         S_DRAW:  if (last_step) state_d = S_WAIT;
         default: state_d = S_WAIT;
      endcase
   end

   // Erase pixels are always background; draw pixels follow the ROM bit that
   // arrives in the plot cycle.
   always_comb begin
      colour = BG_COLOUR;
      if (plot && draw_q && rom_q) colour = FG_COLOUR;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         cx        <= '0;
         cy        <= '0;
         plot      <= 1'b0;
         x         <= '0;
         y         <= '0;
         draw_q    <= 1'b0;
         pos_x     <= '0;
         pos_y     <= 7'(YMAX / 2);
         dir_x     <= 1'b1;
         dir_y     <= 1'b0;
         frame_cnt <= '0;
         pending   <= 1'b0;
      end else begin
         frame_cnt <= tick ? '0 : frame_cnt + FC_W'(1);

         // Plot lags issue by one cycle to line up with the registered ROM.
         plot <= issue;
         if (issue) begin
            x      <= pos_x + 8'(cx);
            y      <= pos_y + 7'(cy);
            draw_q <= (state == S_DRAW);
            if (cx == CX_W'(SPRITE_W - 1)) begin
               cx <= '0;
               cy <= (cy == CY_W'(SPRITE_H - 1)) ? '0 : cy + CY_W'(1);
            end else begin
               cx <= cx + CX_W'(1);
            end
         end else begin
            cx <= '0;
            cy <= '0;
         end

         // At most one tick is remembered while busy.
         if (state == S_WAIT) begin
            if (go) pending <= 1'b0;
         end else if (tick && enable) begin
            pending <= 1'b1;
         end

         if (state == S_MOVE) begin
            if (dir_x && pos_x == 8'(XMAX)) begin
               dir_x <= 1'b0;
               pos_x <= 8'(XMAX - 1);
            end else if (!dir_x && pos_x == 8'd0) begin
               dir_x <= 1'b1;
               pos_x <= 8'd1;
            end else begin
               pos_x <= dir_x ? pos_x + 8'd1 : pos_x - 8'd1;
            end

            if (dir_y && pos_y == 7'(YMAX)) begin
               dir_y <= 1'b0;
               pos_y <= 7'(YMAX - 1);
            end else if (!dir_y && pos_y == 7'd0) begin
               dir_y <= 1'b1;
               pos_y <= 7'd1;
            end else begin
               pos_y <= dir_y ? pos_y + 7'd1 : pos_y - 7'd1;
            end
         end
      end
   end

endmodule
